secuenciador_teclas: RTL and testbench

// - Sequences PS/2 scan bytes from the keyboard receiver into ASCII characters for the rest of the design.
// - Tracks make, break (F0) and extended (E0) prefixes and forwards each make code to the external

---
 rtl/secuenciador_teclas.sv | 128 ++++++++++++
 tb/tb_secuenciador_teclas.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_teclas.sv
// PS/2 scan-byte sequencer: decodes make/break/extended prefixes, forwards make codes to the
// external ASCII lookup and buffers the results in a FIFO. Optional macro: TYPEMATIC_FILTER_EN.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix byte
// BRK     | F0 seen; next byte is a released key
// EXT     | E0 seen; extended key, not supported
// EXT_BRK | E0 F0 seen; next byte is a released extended key
module secuenciador_teclas #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [7:0] key_code,
  input  logic [7:0] ascii_code,
  input  logic       rd,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t state, state_nx;
  logic   load_make;
  logic   brk_byte;
  logic   accept;
  logic   wr_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_make = 1'b0;
    brk_byte  = 1'b0;
    if (rx_done_tick) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hF0)      state_nx = BRK;
          else if (rx_data == 8'hE0) state_nx = EXT;
          else                       load_make = 1'b1;
        end
        BRK: begin
          state_nx = IDLE;
          brk_byte = 1'b1;
        end
        EXT:     state_nx = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] last_make;
  logic       held;

  // A held key repeats its make code; only the first one after a release gets through.
  assign accept = load_make && !(held && (rx_data == last_make));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_make <= 8'h00;
      held      <= 1'b0;
    end else if (accept) begin
      last_make <= rx_data;
      held      <= 1'b1;
    end else if (brk_byte && (rx_data == last_make)) begin
      held      <= 1'b0;
    end
  end
`else
  assign accept = load_make;

  logic unused_brk;
  assign unused_brk = brk_byte;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_code <= 8'h00;
      wr_pend  <= 1'b0;
    end else begin
      wr_pend <= accept;
      if (accept) key_code <= rx_data;
    end
  end

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             do_rd, do_wr;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign ascii_out = mem[rd_ptr[FIFO_AW-1:0]];

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign do_rd = rd && !empty;
  assign do_wr = wr_pend && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= ascii_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr_pend && !do_wr) overflow <= 1'b1;
      else if (clr_ovf)      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_secuenciador_teclas.sv
// Bench for secuenciador_teclas: vector table, hand sequences for timing/FIFO corners,
// and a random byte stream checked against a key-event/queue reference model.
module tb_secuenciador_teclas;

  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] key_code;
  logic [7:0] ascii_code;
  logic       rd = 1'b0;
  logic [7:0] ascii_out;
  logic       empty, full, overflow;
  logic       clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  secuenciador_teclas #(.FIFO_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .key_code(key_code), .ascii_code(ascii_code), .rd(rd), .ascii_out(ascii_out),
    .empty(empty), .full(full), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lut(input logic [7:0] sc);
    case (sc)
      8'h1C: return 8'h41;
      8'h16: return 8'h31;
      8'h1E: return 8'h32;
      8'h26: return 8'h33;
      8'h25: return 8'h34;
      8'h2E: return 8'h35;
      8'h36: return 8'h36;
      8'h3D: return 8'h37;
      8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h45: return 8'h30;
      default: return 8'h2A;
    endcase
  endfunction

  always_comb ascii_code = lut(key_code);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    idle(2);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  // Reference model: key events reduce to a queue of characters.
  logic [7:0] q[$];
  bit         m_ovf, m_brk, m_ext, m_extbrk, m_held;
  logic [7:0] m_last;

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_brk = 0; m_ext = 0; m_extbrk = 0; m_held = 0; m_last = 8'h00;
  endfunction

  function automatic void model_make(input logic [7:0] b);
`ifdef TYPEMATIC_FILTER_EN
    if (m_held && b == m_last) return;
    m_last = b; m_held = 1;
`endif
    if (q.size() == DEPTH) m_ovf = 1;
    else q.push_back(lut(b));
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_extbrk) m_extbrk = 0;
    else if (m_ext) begin
      m_ext = 0;
      if (b == 8'hF0) m_extbrk = 1;
    end else if (m_brk) begin
      m_brk = 0;
      if (b == m_last) m_held = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else model_make(b);
  endfunction

  typedef struct {
    bit         snd;
    logic [7:0] scan;
    bit         rdp;
    logic       exp_empty;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vt[15];
  logic [7:0] fill_codes[16];
  logic [7:0] pool[10];

  initial begin
    vt[0]  = '{1, 8'h1C, 0, 1'b0, 8'h41};
    vt[1]  = '{1, 8'hF0, 0, 1'b0, 8'h41};
    vt[2]  = '{1, 8'h1C, 0, 1'b0, 8'h41};
    vt[3]  = '{0, 8'h00, 1, 1'b1, 8'h00};
    vt[4]  = '{1, 8'hE0, 0, 1'b1, 8'h00};
    vt[5]  = '{1, 8'h75, 0, 1'b1, 8'h00};
    vt[6]  = '{1, 8'hE0, 0, 1'b1, 8'h00};
    vt[7]  = '{1, 8'hF0, 0, 1'b1, 8'h00};
    vt[8]  = '{1, 8'h75, 0, 1'b1, 8'h00};
    vt[9]  = '{1, 8'h45, 0, 1'b0, 8'h30};
    vt[10] = '{1, 8'h16, 0, 1'b0, 8'h30};
    vt[11] = '{0, 8'h00, 1, 1'b0, 8'h31};
    vt[12] = '{0, 8'h00, 1, 1'b1, 8'h00};
    vt[13] = '{0, 8'h00, 1, 1'b1, 8'h00};
    vt[14] = '{1, 8'h1E, 0, 1'b0, 8'h32};
    fill_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                   8'h46, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};
    pool = '{8'h1C, 8'h16, 8'h1E, 8'h45, 8'hF0, 8'hE0, 8'hF0, 8'h2E, 8'h75, 8'h00};

    idle(2);
    chk("reset_empty", {7'd0, empty}, 8'h01);
    chk("reset_full", {7'd0, full}, 8'h00);
    chk("reset_ovf", {7'd0, overflow}, 8'h00);
    chk("reset_key", key_code, 8'h00);
    reset_n = 1'b1;
    idle(1);

    // Latency: key_code one cycle after the tick, FIFO non-empty one cycle later.
    rx_data = 8'h1C; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    chk("lat_key", key_code, 8'h1C);
    chk("lat_empty_n1", {7'd0, empty}, 8'h01);
    @(negedge clk);
    chk("lat_empty_n2", {7'd0, empty}, 8'h00);
    chk("lat_head", ascii_out, 8'h41);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      if (vt[i].snd) send(vt[i].scan);
      if (vt[i].rdp) begin pulse_rd(); idle(1); end
      chk($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, vt[i].exp_empty});
      if (!vt[i].exp_empty) chk($sformatf("vec%0d_head", i), ascii_out, vt[i].exp_head);
      chk($sformatf("vec%0d_ovf", i), {7'd0, overflow}, 8'h00);
    end

    // Fill, overflow, simultaneous read/write at full, set-over-clear.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rx_data = fill_codes[i]; rx_done_tick = 1'b1;
      @(negedge clk);
    end
    rx_done_tick = 1'b0;
    idle(2);
    chk("fill8_full", {7'd0, full}, 8'h01);
    chk("fill8_ovf", {7'd0, overflow}, 8'h00);
    for (int i = 8; i < 16; i++) begin
      rx_data = fill_codes[i]; rx_done_tick = 1'b1;
      @(negedge clk);
    end
    rx_done_tick = 1'b0;
    idle(2);
    chk("fill16_full", {7'd0, full}, 8'h01);
    chk("fill16_ovf", {7'd0, overflow}, 8'h01);
    chk("fill16_head", ascii_out, 8'h31);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_ovf", {7'd0, overflow}, 8'h00);
    rx_data = 8'h1C; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    idle(1);
    chk("rdwr_full", {7'd0, full}, 8'h01);
    chk("rdwr_ovf", {7'd0, overflow}, 8'h00);
    chk("rdwr_head", ascii_out, 8'h32);
    rx_data = 8'h16; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("set_wins", {7'd0, overflow}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), ascii_out, (i == 7) ? 8'h41 : 8'h32 + 8'(i));
      pulse_rd();
    end
    chk("drain_empty", {7'd0, empty}, 8'h01);

    // Typematic repeats.
    begin
      int n, exp_n;
      logic [7:0] tseq[6];
      tseq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef TYPEMATIC_FILTER_EN
      exp_n = 2;
`else
      exp_n = 4;
`endif
      do_reset();
      foreach (tseq[i]) send(tseq[i]);
      n = 0;
      for (int k = 0; k < 2 * DEPTH && !empty; k++) begin
        chk($sformatf("typ_head%0d", k), ascii_out, 8'h41);
        pulse_rd();
        n++;
      end
      chk("typ_count", 8'(n), 8'(exp_n));
    end

    // Random byte stream against the reference model.
    do_reset();
    model_reset();
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [7:0] b;
        b = pool[$urandom_range(0, 9)];
        if (b == 8'h00) b = 8'($urandom);
        send(b);
        model_byte(b);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_rd();
        if (q.size() != 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 7) == 0) begin
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        m_ovf = 0;
      end
      chk("rnd_empty", {7'd0, empty}, {7'd0, q.size() == 0});
      chk("rnd_full", {7'd0, full}, {7'd0, q.size() == DEPTH});
      chk("rnd_ovf", {7'd0, overflow}, {7'd0, m_ovf});
      if (q.size() != 0) chk("rnd_head", ascii_out, q[0]);
    end

    // Asynchronous reset after a break prefix.
    do_reset();
    send(8'h16);
    rx_data = 8'hF0; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_empty", {7'd0, empty}, 8'h01);
    chk("async_full", {7'd0, full}, 8'h00);
    chk("async_ovf", {7'd0, overflow}, 8'h00);
    chk("async_key", key_code, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send(8'h1C);
    chk("post_rst_key", key_code, 8'h1C);
    chk("post_rst_head", ascii_out, 8'h41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
